// File: rtl/seg7_scan_driver_if.sv
// Load-side bus of the 7-segment scan driver: captured word, per-digit
// decimal-point and blank masks, plus the pending (waiting for frame) flag.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_in;
  logic                    pending;

  modport master (output load, value, dp_in, blank_in, input pending);
  modport slave  (input load, value, dp_in, blank_in, output pending);
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver. One digit per slot of REFRESH_DIV cycles,
// the first GHOST_CYCLES of each slot with all enables off (anti-ghosting).
// New data is held in a pending copy and swapped in at the frame boundary so a
// frame never mixes old and new digits.
//
// state    | meaning
// ST_RESET | in reset; next cycle starts slot 0 of digit 0
// ST_GHOST | slot dead time, enables off, segments already show the digit
// ST_DRIVE | enable of the current digit active
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 12000,
  parameter int GHOST_CYCLES = 16,
  parameter bit EN_ACT_LOW   = 1'b1,
  parameter bit SEG_ACT_LOW  = 1'b1,
  parameter bit LZ_BLANK     = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST,
  seg7_scan_driver_if.slave     bus,
  output logic [NUM_DIGITS-1:0] DS_EN,
  output logic [6:0]            DS_SEG,
  output logic                  DS_DP,
  output logic                  frame_start
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {ST_RESET, ST_GHOST, ST_DRIVE} state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic [IW-1:0]           idx, idx_nxt;
  logic [4*NUM_DIGITS-1:0] disp_val, disp_val_nxt, pend_val;
  logic [NUM_DIGITS-1:0]   disp_dp, disp_dp_nxt, pend_dp;
  logic [NUM_DIGITS-1:0]   disp_blank, disp_blank_nxt, pend_blank;
  logic                    pending_q;
  logic                    boundary;
  logic                    upper_zero;
  logic                    dark;
  logic [3:0]              nib;
  logic [6:0]              seg_act;
  logic [NUM_DIGITS-1:0]   en_act;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'h0: decode = 7'h7E;  4'h1: decode = 7'h30;
      4'h2: decode = 7'h6D;  4'h3: decode = 7'h79;
      4'h4: decode = 7'h33;  4'h5: decode = 7'h5B;
      4'h6: decode = 7'h5F;  4'h7: decode = 7'h70;
      4'h8: decode = 7'h7F;  4'h9: decode = 7'h7B;
      4'hA: decode = 7'h77;  4'hB: decode = 7'h1F;
      4'hC: decode = 7'h4E;  4'hD: decode = 7'h3D;
      4'hE: decode = 7'h4F;  default: decode = 7'h47;
    endcase
  endfunction

  assign bus.pending = pending_q;

  // Next scan position, next display contents and the decode of that next state,
  // so the registered pins line up with cnt/idx of the same cycle.
  always_comb begin
    boundary = (state != ST_RESET) && (cnt == CNT_LAST) && (idx == IDX_LAST);

    if (state == ST_RESET) begin
      cnt_nxt = '0;
      idx_nxt = '0;
    end else if (cnt == CNT_LAST) begin
      cnt_nxt = '0;
      idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt_nxt = cnt + 1'b1;
      idx_nxt = idx;
    end

    state_nxt = (int'(cnt_nxt) < GHOST_CYCLES) ? ST_GHOST : ST_DRIVE;

    disp_val_nxt   = disp_val;
    disp_dp_nxt    = disp_dp;
    disp_blank_nxt = disp_blank;
    if (boundary && bus.load) begin
      disp_val_nxt   = bus.value;
      disp_dp_nxt    = bus.dp_in;
      disp_blank_nxt = bus.blank_in;
    end else if (boundary && pending_q) begin
      disp_val_nxt   = pend_val;
      disp_dp_nxt    = pend_dp;
      disp_blank_nxt = pend_blank;
    end

    upper_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i >= int'(idx_nxt) && disp_val_nxt[4*i +: 4] != 4'h0) upper_zero = 1'b0;
    end
    nib  = disp_val_nxt[4*int'(idx_nxt) +: 4];
    dark = disp_blank_nxt[idx_nxt] || (LZ_BLANK && (idx_nxt != '0) && upper_zero);
    seg_act = dark ? 7'h00 : decode(nib);

    en_act = '0;
    if (state_nxt == ST_DRIVE) en_act[idx_nxt] = 1'b1;
  end

  // Scan state, data capture/commit and registered pin drive.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_RESET;
      cnt         <= '0;
      idx         <= '0;
      disp_val    <= '0;
      disp_dp     <= '0;
      disp_blank  <= '0;
      pend_val    <= '0;
      pend_dp     <= '0;
      pend_blank  <= '0;
      pending_q   <= 1'b0;
      frame_start <= 1'b0;
      DS_EN       <= {NUM_DIGITS{EN_ACT_LOW}};
      DS_SEG      <= {7{SEG_ACT_LOW}};
      DS_DP       <= SEG_ACT_LOW;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      disp_val   <= disp_val_nxt;
      disp_dp    <= disp_dp_nxt;
      disp_blank <= disp_blank_nxt;
      if (boundary) begin
        pending_q <= 1'b0;
      end else if (bus.load) begin
        pend_val   <= bus.value;
        pend_dp    <= bus.dp_in;
        pend_blank <= bus.blank_in;
        pending_q  <= 1'b1;
      end
      frame_start <= (cnt_nxt == '0) && (idx_nxt == '0);
      DS_EN       <= en_act ^ {NUM_DIGITS{EN_ACT_LOW}};
      DS_SEG      <= seg_act ^ {7{SEG_ACT_LOW}};
      DS_DP       <= (disp_dp_nxt[idx_nxt] && !dark) ^ SEG_ACT_LOW;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: two instances (leading-zero blanking off/on) fed
// the same stimulus, every cycle compared against a time-indexed reference.
module tb_seg7_scan_driver;
  localparam int N     = 4;
  localparam int DIV   = 8;
  localparam int GH    = 2;
  localparam int FRAME = N * DIV;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  seg7_scan_driver_if #(.NUM_DIGITS(N)) bus0 ();
  seg7_scan_driver_if #(.NUM_DIGITS(N)) bus1 ();

  logic [N-1:0] en0, en1;
  logic [6:0]   seg0, seg1;
  logic         dp0, dp1, fs0, fs1;

  seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .GHOST_CYCLES(GH),
    .EN_ACT_LOW(1'b1), .SEG_ACT_LOW(1'b1), .LZ_BLANK(1'b0)) u_plain (
    .CLK(clk), .RST(rst), .bus(bus0), .DS_EN(en0), .DS_SEG(seg0), .DS_DP(dp0),
    .frame_start(fs0));

  seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .GHOST_CYCLES(GH),
    .EN_ACT_LOW(1'b1), .SEG_ACT_LOW(1'b1), .LZ_BLANK(1'b1)) u_lz (
    .CLK(clk), .RST(rst), .bus(bus1), .DS_EN(en1), .DS_SEG(seg1), .DS_DP(dp1),
    .frame_start(fs1));

  logic [6:0] seg_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                              7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  // reference: cycles since reset release plus shown / waiting data
  int          t;
  bit          running;
  logic [15:0] m_word, m_pword;
  logic [3:0]  m_dp, m_bl, m_pdp, m_pbl;
  bit          m_pf;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, got, exp);
    end
  endtask

  function automatic bit is_dark(input int idx, input bit lz);
    logic [15:0] upper;
    upper = m_word >> (4 * idx);
    return m_bl[idx] || (lz && idx > 0 && upper == 16'h0);
  endfunction

  task automatic check_all();
    int slot, idx;
    logic [3:0]  e_en;
    logic [6:0]  e_seg0, e_seg1;
    logic        e_dp0, e_dp1, e_fs;
    logic [15:0] sh;
    if (!running) begin
      e_en = 4'hF; e_seg0 = 7'h7F; e_seg1 = 7'h7F; e_dp0 = 1'b1; e_dp1 = 1'b1; e_fs = 1'b0;
    end else begin
      slot = t % DIV;
      idx  = (t / DIV) % N;
      e_en = (slot >= GH) ? ~(4'b0001 << idx) : 4'hF;
      sh   = m_word >> (4 * idx);
      e_seg0 = is_dark(idx, 1'b0) ? 7'h7F : ~seg_tab[sh[3:0]];
      e_seg1 = is_dark(idx, 1'b1) ? 7'h7F : ~seg_tab[sh[3:0]];
      e_dp0  = is_dark(idx, 1'b0) ? 1'b1 : ~m_dp[idx];
      e_dp1  = is_dark(idx, 1'b1) ? 1'b1 : ~m_dp[idx];
      e_fs   = (t % FRAME) == 0;
    end
    chk("en",      16'(en0),  16'(e_en));
    chk("seg",     16'(seg0), 16'(e_seg0));
    chk("dp",      16'(dp0),  16'(e_dp0));
    chk("fs",      16'(fs0),  16'(e_fs));
    chk("pend",    16'(bus0.pending), 16'(m_pf));
    chk("lz_en",   16'(en1),  16'(e_en));
    chk("lz_seg",  16'(seg1), 16'(e_seg1));
    chk("lz_dp",   16'(dp1),  16'(e_dp1));
    chk("lz_fs",   16'(fs1),  16'(e_fs));
    chk("lz_pend", 16'(bus1.pending), 16'(m_pf));
  endtask

  task automatic cyc(input bit r, input bit l, input logic [15:0] v,
                     input logic [3:0] d, input logic [3:0] b);
    bit bnd;
    rst = r;
    bus0.load = l; bus0.value = v; bus0.dp_in = d; bus0.blank_in = b;
    bus1.load = l; bus1.value = v; bus1.dp_in = d; bus1.blank_in = b;
    @(posedge clk);
    if (r) begin
      running = 0; t = 0; m_pf = 0;
      m_word = '0; m_dp = '0; m_bl = '0; m_pword = '0; m_pdp = '0; m_pbl = '0;
    end else begin
      bnd = running && (t % FRAME == FRAME - 1);
      if (bnd) begin
        if (l) begin
          m_word = v; m_dp = d; m_bl = b;
        end else if (m_pf) begin
          m_word = m_pword; m_dp = m_pdp; m_bl = m_pbl;
        end
        m_pf = 0;
      end else if (l) begin
        m_pword = v; m_pdp = d; m_pbl = b; m_pf = 1;
      end
      t = running ? t + 1 : 0;
      running = 1;
    end
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
  endtask

  task automatic go_phase(input int ph);
    for (int i = 0; i < FRAME && (t % FRAME) != ph; i++) cyc(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
  endtask

  initial begin
    running = 0; t = 0;
    // reset held 3 cycles
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);

    // scan 1234 over two frames
    cyc(1'b0, 1'b1, 16'h1234, 4'h0, 4'h0);
    idle(70);

    // tear-free double load mid-frame
    go_phase(9);
    cyc(1'b0, 1'b1, 16'hABCD, 4'h0, 4'h0);
    idle(5);
    cyc(1'b0, 1'b1, 16'h00EF, 4'h0, 4'h0);
    idle(40);

    // load exactly on the boundary cycle
    go_phase(FRAME - 1);
    cyc(1'b0, 1'b1, 16'h8888, 4'h0, 4'h0);
    chk("bnd_load_seg", 16'(seg0), 16'h0000);
    idle(35);

    // blank and decimal-point masks
    cyc(1'b0, 1'b1, 16'h5A3C, 4'b0001, 4'b0100);
    idle(70);

    // leading-zero blanking
    cyc(1'b0, 1'b1, 16'h0050, 4'h0, 4'h0);
    idle(66);
    cyc(1'b0, 1'b1, 16'h0000, 4'h0, 4'h0);
    idle(66);

    // reset while a value is pending
    cyc(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    idle(40);
    go_phase(10);
    cyc(1'b0, 1'b1, 16'h1111, 4'hF, 4'h0);
    idle(3);
    cyc(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    cyc(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    idle(40);

    // random loads and occasional resets
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom % 100) == 0, ($urandom % 6) == 0, 16'($urandom),
          4'($urandom), (($urandom % 3) == 0) ? 4'($urandom) : 4'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
